// File: rtl/arb_pkg.sv
// Shared types for the memory arbiter: state encoding, operation kind and
// default widths for addresses and data words.
package arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises icache reads and dcache reads/writes onto a single RAM port.
// dcache wins ties; a saturating counter forces an icache grant after a run of dcache grants.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready
);

  // A zero limit still needs a one-bit counter so the compare below stays legal.
  localparam int CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state;
  op_t               cap_op;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_store;
  logic [CNT_W-1:0]  starve_cnt;

  logic d_req;
  logic force_i;
  logic i_done;
  logic d_done;

  assign d_req   = dREN | dWEN;
  assign force_i = iREN && (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cap_op     <= OP_READ;
      cap_addr   <= '0;
      cap_store  <= '0;
      starve_cnt <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (force_i || (!d_req && iREN)) begin
            state      <= I_ACC;
            cap_op     <= OP_READ;
            cap_addr   <= iaddr;
            cap_store  <= '0;
            starve_cnt <= '0;
            ramREN     <= 1'b1;
            ramWEN     <= 1'b0;
          end else if (d_req) begin
            state     <= D_ACC;
            cap_op    <= dWEN ? OP_WRITE : OP_READ;
            cap_addr  <= daddr;
            cap_store <= dstore;
            ramREN    <= !dWEN;
            ramWEN    <= dWEN;
            // Only a pending icache request makes a dcache grant count as starvation.
            if (!iREN)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        D_ACC, I_ACC: begin
          if (ramready) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

  assign ramaddr  = cap_addr;
  assign ramstore = cap_store;

  assign i_done = (state == I_ACC) && ramready;
  assign d_done = (state == D_ACC) && ramready;

  // Completion is reported in the same cycle ramready arrives, with read data passed straight through.
  always_comb begin
    iwait = 1'b1;
    dwait = 1'b1;
    iload = '0;
    dload = '0;
    if (i_done) begin
      iwait = 1'b0;
      iload = ramload;
    end
    if (d_done) begin
      dwait = 1'b0;
      if (cap_op == OP_READ)
        dload = ramload;
    end
  end

endmodule
